// File: rtl/x_times2.sv
// GF(2^8) xtime: combinational single doubling per lane plus a registered 2^k multiplier.
// Optional macro XTIME_RED_FLAG_EN adds the per-lane reduction flag output red_o.
module x_times2 #(
  parameter int unsigned LANES = 1,
  parameter logic [7:0]  POLY  = 8'h1B
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [8*LANES-1:0]   b_i,
  output logic [8*LANES-1:0]   b_o,
  input  logic                 valid_i,
  input  logic [2:0]           k_i,
  output logic [8*LANES-1:0]   p_o,
  output logic                 valid_o
`ifdef XTIME_RED_FLAG_EN
  ,
  output logic [LANES-1:0]     red_o
`endif
);

  localparam int unsigned W = 8 * LANES;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  // Seven-stage doubling ladder, selected by k.
  function automatic logic [7:0] mul_pow2(input logic [7:0] b, input logic [2:0] k);
    logic [7:0] st [8];
    st[0] = b;
    for (int j = 1; j < 8; j++) begin
      st[j] = xtime(st[j-1]);
    end
    return st[k];
  endfunction

`ifdef XTIME_RED_FLAG_EN
  // Set when any of the first k ladder stages fed a set bit 7 into the next doubling.
  function automatic logic red_any(input logic [7:0] b, input logic [2:0] k);
    logic [7:0] st [8];
    logic       red;
    st[0] = b;
    red   = 1'b0;
    for (int j = 1; j < 8; j++) begin
      st[j] = xtime(st[j-1]);
    end
    for (int j = 0; j < 7; j++) begin
      if (3'(j) < k) red = red | st[j][7];
    end
    return red;
  endfunction

  logic [LANES-1:0] w_red;
  logic [LANES-1:0] r_red;
`endif

  logic [W-1:0] w_p;
  logic [W-1:0] r_p;
  logic         r_valid;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    assign b_o[8*n +: 8] = xtime(b_i[8*n +: 8]);
    assign w_p[8*n +: 8] = mul_pow2(b_i[8*n +: 8], k_i);
`ifdef XTIME_RED_FLAG_EN
    assign w_red[n] = red_any(b_i[8*n +: 8], k_i);
`endif
  end

  // Result register: loads on valid, holds otherwise; reset wins over valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_p     <= '0;
`ifdef XTIME_RED_FLAG_EN
      r_red   <= '0;
`endif
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_p   <= w_p;
`ifdef XTIME_RED_FLAG_EN
        r_red <= w_red;
`endif
      end
    end
  end

  assign p_o     = r_p;
  assign valid_o = r_valid;
`ifdef XTIME_RED_FLAG_EN
  assign red_o   = r_red;
`endif

endmodule

// File: tb/tb_x_times2.sv
// Self-checking bench for x_times2 (LANES=1 and LANES=4) against a GF(2^8) multiply model.
module tb_x_times2;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [2:0]  k;
  logic [7:0]  b1;
  logic [31:0] b4;
  logic [7:0]  bo1, po1;
  logic [31:0] bo4, po4;
  logic        vo1, vo4;
`ifdef XTIME_RED_FLAG_EN
  logic        red1;
  logic [3:0]  red4;
`endif

  int checks   = 0;
  int failures = 0;

  x_times2 #(.LANES(1), .POLY(8'h1B)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .b_i(b1), .b_o(bo1), .valid_i(valid), .k_i(k),
    .p_o(po1), .valid_o(vo1)
`ifdef XTIME_RED_FLAG_EN
    , .red_o(red1)
`endif
  );

  x_times2 #(.LANES(4), .POLY(8'h1B)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .b_i(b4), .b_o(bo4), .valid_i(valid), .k_i(k),
    .p_o(po4), .valid_o(vo4)
`ifdef XTIME_RED_FLAG_EN
    , .red_o(red4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full carry-less multiply then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (m[i]) prod = prod ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011B << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] m_pow(input logic [7:0] a, input logic [2:0] kk);
    logic [7:0] m;
    m = 8'(1 << kk);
    return gf_mul(a, m);
  endfunction

  function automatic logic [31:0] m_pow4(input logic [31:0] a, input logic [2:0] kk);
    logic [31:0] r;
    for (int n = 0; n < 4; n++) r[8*n +: 8] = m_pow(a[8*n +: 8], kk);
    return r;
  endfunction

  // A reduction happens iff some bit gets shifted past bit 7 before any reduction.
  function automatic logic m_red(input logic [7:0] a, input logic [2:0] kk);
    logic [15:0] s;
    s = 16'(a) << kk;
    return s[15:8] != 8'h00;
  endfunction

  function automatic logic [3:0] m_red4(input logic [31:0] a, input logic [2:0] kk);
    logic [3:0] r;
    for (int n = 0; n < 4; n++) r[n] = m_red(a[8*n +: 8], kk);
    return r;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [2:0] kk,
                       input logic [7:0] x1, input logic [31:0] x4);
    @(negedge clk);
    rst = r; valid = v; k = kk; b1 = x1; b4 = x4;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  comb_in  [8] = '{8'h57, 8'hAE, 8'h47, 8'h8E, 8'h80, 8'hFF, 8'h00, 8'h01};
  logic [7:0]  comb_exp [8] = '{8'hAE, 8'h47, 8'h8E, 8'h07, 8'h1B, 8'hE5, 8'h00, 8'h02};

  logic        e_v;
  logic [7:0]  e_p1;
  logic [31:0] e_p4;
  logic        e_r1;
  logic [3:0]  e_r4;

  initial begin
    rst = 1'b1; valid = 1'b0; k = 3'd0; b1 = 8'h00; b4 = 32'h0;
    step();
    step();
    chk("rst_p1", 32'(po1), 32'h0);
    chk("rst_v1", 32'(vo1), 32'h0);
    chk("rst_p4", po4, 32'h0);

    drive(1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
    for (int i = 0; i < 8; i++) begin
      b1 = comb_in[i];
      #1;
      chk($sformatf("comb_%02h", comb_in[i]), 32'(bo1), 32'(comb_exp[i]));
    end

    drive(1'b0, 1'b1, 3'd4, 8'h57, 32'h0);
    step();
    chk("k4_p", 32'(po1), 32'h07);
    chk("k4_v", 32'(vo1), 32'h1);
    drive(1'b0, 1'b1, 3'd0, 8'h57, 32'h0);
    step();
    chk("k0_p", 32'(po1), 32'h57);

    drive(1'b0, 1'b1, 3'd1, 8'h13, 32'h0);
    step();
    chk("b2b0_p", 32'(po1), 32'h26);
    chk("b2b0_v", 32'(vo1), 32'h1);
    drive(1'b0, 1'b1, 3'd1, 8'h20, 32'h0);
    step();
    chk("b2b1_p", 32'(po1), 32'h40);
    chk("b2b1_v", 32'(vo1), 32'h1);
    drive(1'b0, 1'b0, 3'd5, 8'hFF, 32'h0);
    step();
    chk("hold_v", 32'(vo1), 32'h0);
    chk("hold_p", 32'(po1), 32'h40);
    step();
    chk("hold2_p", 32'(po1), 32'h40);

    drive(1'b0, 1'b1, 3'd1, 8'h00, 32'h80FF0157);
    #1;
    chk("l4_bo", bo4, 32'h1BE502AE);
    step();
    chk("l4_po", po4, 32'h1BE502AE);
`ifdef XTIME_RED_FLAG_EN
    chk("l4_red", 32'(red4), 32'hC);
`endif

    drive(1'b1, 1'b1, 3'd1, 8'h57, 32'h80FF0157);
    step();
    chk("rstm_p1", 32'(po1), 32'h0);
    chk("rstm_v1", 32'(vo1), 32'h0);
    chk("rstm_p4", po4, 32'h0);
    chk("rstm_bo", 32'(bo1), 32'hAE);
`ifdef XTIME_RED_FLAG_EN
    chk("rstm_red", 32'(red4), 32'h0);
`endif

    e_v = 1'b0; e_p1 = 8'h0; e_p4 = 32'h0; e_r1 = 1'b0; e_r4 = 4'h0;
    for (int it = 0; it < 300; it++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 8'($urandom), $urandom);
      #1;
      chk("rnd_bo1", 32'(bo1), 32'(gf_mul(b1, 8'h02)));
      chk("rnd_bo4", bo4, m_pow4(b4, 3'd1));
      if (rst) begin
        e_v = 1'b0; e_p1 = 8'h0; e_p4 = 32'h0; e_r1 = 1'b0; e_r4 = 4'h0;
      end else begin
        e_v = valid;
        if (valid) begin
          e_p1 = m_pow(b1, k);
          e_p4 = m_pow4(b4, k);
          e_r1 = m_red(b1, k);
          e_r4 = m_red4(b4, k);
        end
      end
      step();
      chk("rnd_v1", 32'(vo1), 32'(e_v));
      chk("rnd_v4", 32'(vo4), 32'(e_v));
      chk("rnd_p1", 32'(po1), 32'(e_p1));
      chk("rnd_p4", po4, e_p4);
`ifdef XTIME_RED_FLAG_EN
      chk("rnd_r1", 32'(red1), 32'(e_r1));
      chk("rnd_r4", 32'(red4), 32'(e_r4));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/x_times2.md
Name: x_times2

Overview:
- GF(2^8) "xtime" block: multiplies each byte lane by x (0x02) modulo the field polynomial.
- Combinational single-doubling output `b_o` feeds chained instances, e.g. the 0x02…0x80 ladder used by gf_square.
- Registered path multiplies each lane by 2^k (k = 0..7) with valid tracking and 1-cycle latency, for pipelined AES datapaths.

Parameters:
- LANES, 1, number of independent byte lanes; bus width = 8*LANES.
- POLY, 8'h1B, low 8 bits of the reduction polynomial (x^8+x^4+x^3+x+1 for AES).

Ports:
- clk_i  input  1  clock; all registered state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- b_i  input  8*LANES  operand bytes; lane n = b_i[8n+7:8n].
- b_o  output  8*LANES  combinational xtime(b_i) per lane.
- valid_i  input  1  qualifies b_i/k_i for the registered path.
- k_i  input  3  number of doublings for the registered path, 0..7.
- p_o  output  8*LANES  registered per-lane product b_i * 2^k_i.
- valid_o  output  1  p_o holds a result captured on the previous edge.

Behaviour:
- xtime(b) = {b[6:0],1'b0} ^ (b[7] ? POLY : 8'h00). Lanes are fully independent; no carry between lanes.
- b_o:
  - Purely combinational. Zero latency.
  - Unaffected by clk_i, rst_i, valid_i and k_i.
  - Must stay combinational so instances can be chained in one cycle.
- Registered path: p = xtime applied k_i times to each lane, computed as a 7-stage combinational unroll muxed by k_i.
  - k_i=0 gives p = b_i unchanged.
  - k_i=7 is equivalent to multiplying by 0x80.
- On rising clk_i with rst_i=1: valid_o←0, p_o←0 (all lanes), red_o←0 if present. Reset takes priority over valid_i. Reset mid-stream discards the pending result.
- On rising clk_i with rst_i=0:
  - valid_o←valid_i.
  - If valid_i=1: p_o←p.
  - If valid_i=0: p_o holds its previous value.
- Latency: 1 cycle from valid_i to valid_o.
- Throughput: one new operand per cycle. No backpressure and no ready signal; back-to-back valid_i is legal.
- Boundary values:
  - 0x00 maps to 0x00 for any k.
  - 0x80 with k=1 maps to POLY.
  - b[7]=0 means a plain left shift with no reduction.
- No X propagation: p_o and valid_o are defined from the first reset onward. Before the first reset they are unspecified.

Optional Feature:
- Macro: XTIME_RED_FLAG_EN.
- When defined, adds output red_o [LANES-1:0], registered alongside p_o.
  - red_o[n]=1 iff at least one of the k_i doublings for lane n had bit 7 set, i.e. a POLY reduction was applied.
  - red_o resets to 0 and holds when valid_i=0.
- When not defined, the port and its logic are absent. All other behaviour is identical.

Test Plan:
- LANES=1, b_i=0x57 -> b_o=0xAE. b_i=0xAE -> b_o=0x47. b_i=0x47 -> b_o=0x8E. b_i=0x8E -> b_o=0x07. All checked combinationally with no clock edge.
- Edge values: b_i=0x80 -> b_o=0x1B. b_i=0xFF -> b_o=0xE5. b_i=0x00 -> b_o=0x00. b_i=0x01 -> b_o=0x02.
- Registered: valid_i=1, b_i=0x57, k_i=4 -> one edge later p_o=0x07, valid_o=1. With k_i=0 -> p_o=0x57.
- Hold and back-to-back (LANES=1):
  - Send b_i=0x13 with k_i=1, then 0x20 with k_i=1, on consecutive cycles -> p_o=0x26, then 0x40, with valid_o high both cycles.
  - Then drop valid_i -> valid_o=0, p_o stays 0x40.
- Reset: rst_i=1 while valid_i=1 -> next edge p_o=0x00, valid_o=0 (red_o=0 if XTIME_RED_FLAG_EN); b_o still tracks b_i combinationally.
- LANES=4, b_i=0x80_FF_01_57, k_i=1 -> b_o and p_o = 0x1B_E5_02_AE. With XTIME_RED_FLAG_EN, red_o=4'b1100.
